// File: rtl/datamem_ctrl_if.sv
// Core-side request bus and memory-side pin bundle of the data memory controller.
// slave = controller view, master = core plus memory environment view.
interface datamem_ctrl_if #(
    parameter int SZ_LOG2 = 16
) ();
    logic               req;
    logic               wr;
    logic [SZ_LOG2-1:0] addr;
    logic [7:0]         wdata;
    logic               ack;
    logic [7:0]         rdata;
    logic               busy;
    logic               mem_ce;
    logic               mem_we;
    logic [SZ_LOG2-1:0] mem_addr;
    logic [7:0]         mem_din;
    logic [7:0]         mem_dout;

    modport slave (
        input  req, wr, addr, wdata, mem_dout,
        output ack, rdata, busy, mem_ce, mem_we, mem_addr, mem_din
    );

    modport master (
        output req, wr, addr, wdata, mem_dout,
        input  ack, rdata, busy, mem_ce, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/datamem_ctrl.sv
// Single-request sequencer driving a byte-wide data memory with registered ce/we/addr/din.
// Optional feature macro: DATAMEM_CTRL_POSTED_WR_EN (writes acknowledge in SETUP).
module datamem_ctrl #(
    parameter int SZ_LOG2 = 16,
    parameter int WAIT    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    datamem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic               r_wr;
    logic               r_mem_ce;
    logic               r_mem_we;
    logic               r_ack;
    logic               r_busy;
    logic [7:0]         r_rdata;
    logic [SZ_LOG2-1:0] r_mem_addr;
    logic [7:0]         r_mem_din;
    logic               w_accept;
    logic               w_ack_nxt;

    assign w_accept = (r_state == S_IDLE) && bus.req;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.req) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_state_nxt = r_wr ? S_WRITE : S_DONE;
            S_WRITE:  w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

`ifdef DATAMEM_CTRL_POSTED_WR_EN
    // Posted writes acknowledge on entry to SETUP; their DONE stays silent.
    always_comb begin
        w_ack_nxt = 1'b0;
        if (w_accept && bus.wr)
            w_ack_nxt = 1'b1;
        else if (w_state_nxt == S_DONE && !r_wr)
            w_ack_nxt = 1'b1;
    end
`else
    always_comb begin
        w_ack_nxt = (w_state_nxt == S_DONE);
    end
`endif

    // Outputs are decoded from the next state so every memory pin comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= 8'h00;
            r_mem_addr <= '0;
            r_mem_din  <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_ce <= (w_state_nxt == S_ACCESS) || (w_state_nxt == S_WRITE);
            r_mem_we <= (w_state_nxt == S_WRITE);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_ack    <= w_ack_nxt;
            if (w_accept) begin
                r_wr       <= bus.wr;
                r_mem_addr <= bus.addr;
                r_mem_din  <= bus.wdata;
            end
            if (r_state == S_SETUP)
                r_cnt <= 4'(WAIT);
            else if (r_state == S_ACCESS && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == S_ACCESS && r_cnt == 4'd0 && !r_wr)
                r_rdata <= bus.mem_dout;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.mem_ce   = r_mem_ce;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
endmodule

// File: tb/tb_datamem_ctrl.sv
// Bench for datamem_ctrl: two instances (WAIT=0 and WAIT=3), each with a behavioural byte memory.
module tb_datamem_ctrl;
    logic clk = 1'b0;
    logic rst_n0 = 1'b0;
    logic rst_n1 = 1'b0;
    always #5 clk = ~clk;

    datamem_ctrl_if #(.SZ_LOG2(16)) b0 ();
    datamem_ctrl_if #(.SZ_LOG2(16)) b1 ();

    datamem_ctrl #(.SZ_LOG2(16), .WAIT(0)) u_dut0 (.clk(clk), .rst_n(rst_n0), .bus(b0.slave));
    datamem_ctrl #(.SZ_LOG2(16), .WAIT(3)) u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(b1.slave));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_a  = 16'h0;
    logic [7:0]  pre_d  = 8'h0;
    int          xwr    = 0;
    int          ph_err = 0;

    assign b0.mem_dout = (b0.mem_ce && !b0.mem_we) ? mem0[b0.mem_addr] : 8'hxx;
    assign b1.mem_dout = (b1.mem_ce && !b1.mem_we) ? mem1[b1.mem_addr] : 8'hxx;

    always @(posedge clk) begin
        if (pre_we) mem0[pre_a] <= pre_d;
        else if (b0.mem_ce && b0.mem_we) mem0[b0.mem_addr] <= b0.mem_din;
        if (b1.mem_ce && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_din;
        if ((b0.mem_ce && b0.mem_we && $isunknown(b0.mem_din)) ||
            (b1.mem_ce && b1.mem_we && $isunknown(b1.mem_din)))
            xwr <= xwr + 1;
    end

    // Phase monitor: addr/din frozen while ce is high and during the cycle before it rises,
    // we only after at least one ce-only cycle.
    logic        p_ce0 = 1'b0, p_ce1 = 1'b0;
    logic [15:0] p_a0 = 16'h0, p_a1 = 16'h0;
    logic [7:0]  p_d0 = 8'h0, p_d1 = 8'h0;
    always @(negedge clk) begin
        if (b0.mem_ce && (b0.mem_addr !== p_a0 || b0.mem_din !== p_d0)) ph_err <= ph_err + 1;
        if (b0.mem_we && !(b0.mem_ce && p_ce0)) ph_err <= ph_err + 1;
        if (b1.mem_ce && (b1.mem_addr !== p_a1 || b1.mem_din !== p_d1)) ph_err <= ph_err + 1;
        if (b1.mem_we && !(b1.mem_ce && p_ce1)) ph_err <= ph_err + 1;
        p_ce0 <= b0.mem_ce; p_a0 <= b0.mem_addr; p_d0 <= b0.mem_din;
        p_ce1 <= b1.mem_ce; p_a1 <= b1.mem_addr; p_d1 <= b1.mem_din;
    end

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int         ack_cyc, ack_n, ce_n, busy_last;
    logic [7:0] rd;

`ifdef DATAMEM_CTRL_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one request and observes 12 cycles after the acceptance edge.
    task automatic run_txn(input int sel, input logic w, input logic [15:0] a, input logic [7:0] d,
                           output int o_ack_cyc, output int o_ack_n, output int o_ce_n,
                           output int o_busy_last, output logic [7:0] o_rd);
        logic s_ack, s_ce, s_busy;
        logic [7:0] s_rd;
        o_ack_cyc = -1; o_ack_n = 0; o_ce_n = 0; o_busy_last = -1; o_rd = 8'h00;
        @(posedge clk); #1;
        if (sel == 0) begin b0.req = 1'b1; b0.wr = w; b0.addr = a; b0.wdata = d; end
        else          begin b1.req = 1'b1; b1.wr = w; b1.addr = a; b1.wdata = d; end
        @(posedge clk); #1;
        b0.req = 1'b0; b1.req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            s_ack  = (sel == 0) ? b0.ack    : b1.ack;
            s_ce   = (sel == 0) ? b0.mem_ce : b1.mem_ce;
            s_busy = (sel == 0) ? b0.busy   : b1.busy;
            s_rd   = (sel == 0) ? b0.rdata  : b1.rdata;
            if (s_ack) begin
                if (o_ack_n == 0) begin o_ack_cyc = c; o_rd = s_rd; end
                o_ack_n++;
            end
            if (s_ce) o_ce_n++;
            if (s_busy) o_busy_last = c;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({b0.ack, b0.busy, b0.mem_ce, b0.mem_we, b0.rdata, b0.mem_addr, b0.mem_din} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_w0: got ack=%b busy=%b ce=%b we=%b rdata=%h addr=%h din=%h, want all 0",
                     b0.ack, b0.busy, b0.mem_ce, b0.mem_we, b0.rdata, b0.mem_addr, b0.mem_din);
        end
        n_chk++;
        if ({b1.ack, b1.busy, b1.mem_ce, b1.mem_we, b1.rdata, b1.mem_addr, b1.mem_din} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_w3: got ack=%b busy=%b ce=%b rdata=%h addr=%h, want all 0",
                     b1.ack, b1.busy, b1.mem_ce, b1.rdata, b1.mem_addr);
        end
        rst_n0 = 1'b1; rst_n1 = 1'b1;
    endtask

    task automatic test_read_wait0();
        preload(16'h1234, 8'h5A);
        sb.push_back('{cyc: 3, data: 8'h5A});
        run_txn(0, 1'b0, 16'h1234, 8'h00, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || ack_n !== 1) begin
            n_fail++; $display("FAIL read_w0_ack: got cycle %0d (count %0d), want cycle %0d (count 1)", ack_cyc, ack_n, e.cyc);
        end
        n_chk++;
        if (rd !== e.data || $isunknown(rd)) begin
            n_fail++; $display("FAIL read_w0_data: got %h, want %h", rd, e.data);
        end
    endtask

    task automatic test_write_read();
        sb.push_back('{cyc: POSTED ? 1 : 4, data: 8'h00});
        run_txn(0, 1'b1, 16'h0010, 8'hA5, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || ack_n !== 1) begin
            n_fail++; $display("FAIL write_w0_ack: got cycle %0d (count %0d), want cycle %0d", ack_cyc, ack_n, e.cyc);
        end
        sb.push_back('{cyc: 3, data: 8'hA5});
        run_txn(0, 1'b0, 16'h0010, 8'h00, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || rd !== e.data) begin
            n_fail++; $display("FAIL readback_0010: got cycle %0d data %h, want cycle %0d data %h", ack_cyc, rd, e.cyc, e.data);
        end
        n_chk++;
        if (xwr !== 0) begin
            n_fail++; $display("FAIL no_x_store: got %0d unknown writes, want 0", xwr);
        end
    endtask

    task automatic test_wait3();
        sb.push_back('{cyc: POSTED ? 1 : 7, data: 8'h00});
        run_txn(1, 1'b1, 16'h0040, 8'h77, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || ce_n !== 5) begin
            n_fail++; $display("FAIL write_w3: got ack cycle %0d ce cycles %0d, want %0d and 5", ack_cyc, ce_n, e.cyc);
        end
        sb.push_back('{cyc: 6, data: 8'h77});
        run_txn(1, 1'b0, 16'h0040, 8'h00, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || ce_n !== 4) begin
            n_fail++; $display("FAIL read_w3_timing: got ack cycle %0d ce cycles %0d, want %0d and 4", ack_cyc, ce_n, e.cyc);
        end
        n_chk++;
        if (rd !== e.data) begin
            n_fail++; $display("FAIL read_w3_data: got %h, want %h", rd, e.data);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cnt = 0;
        int last_acc = 0;
        logic pbusy = 1'b0;
        int sp[$];
        @(posedge clk); #1;
        b0.req = 1'b1; b0.wr = 1'b0; b0.addr = 16'h1234; b0.wdata = 8'h42;
        for (int c = 1; c <= 60 && acc_cnt < 5; c++) begin
            @(negedge clk);
            if (b0.busy && !pbusy) begin
                if (acc_cnt > 0) begin
                    n_chk++;
                    if ((c - 1 - last_acc) !== sp[0]) begin
                        n_fail++; $display("FAIL b2b_spacing_%0d: got %0d cycles, want %0d", acc_cnt, c - 1 - last_acc, sp[0]);
                    end
                    void'(sp.pop_front());
                end
                sp.push_back(b0.wr ? 5 : 4);
                last_acc = c - 1;
                acc_cnt++;
                if (acc_cnt == 5) b0.req = 1'b0;
            end
            if (b0.ack) begin
                b0.wr = ~b0.wr;
                b0.addr = b0.addr + 16'h0101;
            end
            pbusy = b0.busy;
        end
        b0.req = 1'b0;
        repeat (12) @(negedge clk);
        n_chk++;
        if (acc_cnt !== 5) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d accepts within budget, want 5", acc_cnt);
        end
        n_chk++;
        if (ph_err !== 0) begin
            n_fail++; $display("FAIL phase_order: got %0d violations, want 0", ph_err);
        end
    endtask

    task automatic test_reset_mid_write();
        logic seen_ack = 1'b0;
        logic hit = 1'b0;
        run_txn(0, 1'b1, 16'h0020, 8'h11, ack_cyc, ack_n, ce_n, busy_last, rd);
        @(posedge clk); #1;
        b0.req = 1'b1; b0.wr = 1'b1; b0.addr = 16'h0020; b0.wdata = 8'h99;
        @(posedge clk); #1;
        b0.req = 1'b0;
        for (int c = 1; c <= 10 && !hit; c++) begin
            @(negedge clk);
            if (b0.ack) seen_ack = 1'b1;
            if (b0.mem_we) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++; $display("FAIL rst_mid_write_reach: got no WRITE phase in 10 cycles, want mem_we=1");
        end
        rst_n0 = 1'b0;
        #1;
        n_chk++;
        if ({b0.ack, b0.busy, b0.mem_ce, b0.mem_we, b0.rdata, b0.mem_addr, b0.mem_din} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_write_outputs: got ack=%b busy=%b ce=%b we=%b rdata=%h addr=%h din=%h, want all 0",
                     b0.ack, b0.busy, b0.mem_ce, b0.mem_we, b0.rdata, b0.mem_addr, b0.mem_din);
        end
        if (!POSTED) begin
            n_chk++;
            if (seen_ack !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_write_no_ack: got ack=1 before reset, want 0");
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n0 = 1'b1;
        sb.push_back('{cyc: 3, data: 8'h11});
        run_txn(0, 1'b0, 16'h0020, 8'h00, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || rd !== e.data) begin
            n_fail++; $display("FAIL rst_mid_write_readback: got cycle %0d data %h, want cycle %0d data %h", ack_cyc, rd, e.cyc, e.data);
        end
    endtask

    task automatic test_posted();
        sb.push_back('{cyc: POSTED ? 1 : 4, data: 8'h00});
        run_txn(0, 1'b1, 16'h0050, 8'h3C, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (ack_cyc !== e.cyc || ack_n !== 1) begin
            n_fail++; $display("FAIL posted_ack: got cycle %0d (count %0d), want cycle %0d (count 1)", ack_cyc, ack_n, e.cyc);
        end
        n_chk++;
        if (busy_last !== 4) begin
            n_fail++; $display("FAIL posted_busy: got last busy cycle %0d, want 4", busy_last);
        end
        sb.push_back('{cyc: 3, data: 8'h3C});
        run_txn(0, 1'b0, 16'h0050, 8'h00, ack_cyc, ack_n, ce_n, busy_last, rd);
        e = sb.pop_front();
        n_chk++;
        if (rd !== e.data || busy_last !== 3) begin
            n_fail++; $display("FAIL posted_readback: got data %h last busy %0d, want %h and 3", rd, busy_last, e.data);
        end
    endtask

    initial begin
        b0.req = 1'b0; b0.wr = 1'b0; b0.addr = 16'h0; b0.wdata = 8'h0;
        b1.req = 1'b0; b1.wr = 1'b0; b1.addr = 16'h0; b1.wdata = 8'h0;
        test_reset();
        test_read_wait0();
        test_write_read();
        test_wait3();
        test_back_to_back();
        test_reset_mid_write();
        test_posted();
        n_chk++;
        if (ph_err !== 0 || xwr !== 0) begin
            n_fail++; $display("FAIL final_monitors: got phase errors %0d x-writes %0d, want 0 and 0", ph_err, xwr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
